// File: rtl/toggle_count_engine_pkg.sv
// Shared types for the toggle/shift/count bit-statistics engine.
package toggle_count_pkg;

    // Engine control states: waiting for start, shifting N bits, result pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encodings of the count_sel input.
    localparam logic CNT_ONES  = 1'b0;
    localparam logic CNT_EDGES = 1'b1;

endpackage

// File: rtl/toggle_count_engine_if.sv
// Handshake, mode and result bundle of the toggle_count_engine.
// The master side requests runs; the slave side is the engine.
interface toggle_count_engine_if #(
    parameter int N = 64,
    parameter int H = 8
);
    logic         start;
    logic         load_mode;
    logic         count_sel;
    logic [N-1:0] par_in;
    logic         D;
    logic         busy;
    logic         done;
    logic [H-1:0] out;
    logic         overflow;

    modport master (
        output start, load_mode, count_sel, par_in, D,
        input  busy, done, out, overflow
    );

    modport slave (
        input  start, load_mode, count_sel, par_in, D,
        output busy, done, out, overflow
    );
endinterface

// File: rtl/toggle_count_engine_sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// clr has priority over inc; an increment at full scale holds the count
// and raises ovf, which stays set until the next clr.
module sat_counter #(
    parameter int H = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [H-1:0] q,
    output logic         ovf
);
    localparam logic [H-1:0] MAX_COUNT = '1;

    logic [H-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;

    // Next count: clear, saturate-and-flag at full scale, or step by one.
    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (q_q == MAX_COUNT) begin
                ovf_d = 1'b1;
            end else begin
                q_d = q_q + 1'b1;
            end
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/toggle_count_engine.sv
// Bit-statistics engine: a T-flop feeds the serial end of an N-bit shift
// register; each run shifts the register N times and counts either the ones
// leaving the MSB or the transitions between consecutive MSB bits.
module toggle_count_engine
    import toggle_count_pkg::*;
#(
    parameter int N = 64,
    parameter int H = 8
) (
    input logic                 clock,
    input logic                 reset,
    toggle_count_engine_if.slave bus
);
    localparam int BW = $clog2(N + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(N - 1);

    state_t         state_q;
    logic           tq_q;
    logic [N-1:0]   sreg_q;
    logic           prevMsb_q;
    logic [BW-1:0]  idx_q;
    logic           countSel_q;
    logic           busy_q;
    logic           done_q;

    logic           msbBit;
    logic           incReq;
    logic           clrReq;

    // Bit under evaluation is the pre-shift MSB; derive the counter controls.
    always_comb begin
        msbBit = sreg_q[N-1];
        clrReq = (state_q == IDLE) && bus.start;
        incReq = 1'b0;
        if (state_q == SHIFT) begin
            incReq = (countSel_q == CNT_ONES) ? msbBit : (msbBit ^ prevMsb_q);
        end
    end

    // T-flop toggles whenever D is high, regardless of engine state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tq_q <= 1'b0;
        end else begin
            tq_q <= tq_q ^ bus.D;
        end
    end

    // Run control FSM with shift register, index and registered handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            prevMsb_q  <= 1'b0;
            idx_q      <= '0;
            countSel_q <= CNT_ONES;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        countSel_q <= bus.count_sel;
                        prevMsb_q  <= 1'b0;
                        idx_q      <= '0;
                        if (bus.load_mode) begin
                            sreg_q <= bus.par_in;
                        end
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg_q    <= {sreg_q[N-2:0], tq_q};
                    prevMsb_q <= msbBit;
                    idx_q     <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .H(H)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (clrReq),
        .inc   (incReq),
        .q     (bus.out),
        .ovf   (bus.overflow)
    );

    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_toggle_count_engine.sv
// Bench for toggle_count_engine: two engines (N=8 with H=4 and H=2) share the
// same stimulus; a run-level reference model predicts handshake and results.
module tb_toggle_count_engine;
    localparam int N = 8;
    localparam int MAX4 = 15;
    localparam int MAX2 = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;

    toggle_count_engine_if #(.N(N), .H(4)) bus4 ();
    toggle_count_engine_if #(.N(N), .H(2)) bus2 ();

    toggle_count_engine #(.N(N), .H(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4.slave)
    );

    toggle_count_engine #(.N(N), .H(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit           mTq;
    logic [N-1:0] mReg;
    int           mLeft;
    bit           mBusy;
    bit           mDone;
    bit           mQ[$];
    int           mOut4, mOut2;
    bit           mOvf4, mOvf2;

    // Count ones, or transitions from an implied leading 0, MSB first.
    function automatic int countBits(logic [N-1:0] v, bit edges);
        int c = 0;
        bit prev = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (edges) c += (v[i] != prev) ? 1 : 0;
            else       c += v[i] ? 1 : 0;
            prev = v[i];
        end
        return c;
    endfunction

    function automatic int satTo(int c, int maxV);
        return (c > maxV) ? maxV : c;
    endfunction

    task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mTq   = 1'b0;
        mReg  = '0;
        mLeft = 0;
        mBusy = 1'b0;
        mDone = 1'b0;
        mOut4 = 0;
        mOut2 = 0;
        mOvf4 = 1'b0;
        mOvf2 = 1'b0;
        mQ.delete();
    endtask

    // One clock edge of the model, given the inputs present before the edge.
    task automatic modelEdge(bit st, bit ld, bit sel, logic [N-1:0] par, bit d);
        logic [N-1:0] v;
        int cnt;
        if (mDone) begin
            mDone = 1'b0;
            mBusy = 1'b0;
        end else if (mLeft > 0) begin
            mQ.push_back(mTq);
            mLeft--;
            if (mLeft == 0) begin
                for (int i = 0; i < N; i++) mReg[N-1-i] = mQ[i];
                mQ.delete();
                mDone = 1'b1;
            end
        end else if (st) begin
            v     = ld ? par : mReg;
            cnt   = countBits(v, sel);
            mOut4 = satTo(cnt, MAX4);
            mOvf4 = (cnt > MAX4);
            mOut2 = satTo(cnt, MAX2);
            mOvf2 = (cnt > MAX2);
            mBusy = 1'b1;
            mLeft = N;
        end
        mTq = mTq ^ d;
    endtask

    // Compare both engines against the model; results only when settled.
    task automatic checkOutput();
        checkVal("busy4", 32'(bus4.busy), 32'(mBusy));
        checkVal("done4", 32'(bus4.done), 32'(mDone));
        checkVal("busy2", 32'(bus2.busy), 32'(mBusy));
        checkVal("done2", 32'(bus2.done), 32'(mDone));
        if (!mBusy || mDone) begin
            checkVal("out4", 32'(bus4.out), mOut4);
            checkVal("ovf4", 32'(bus4.overflow), 32'(mOvf4));
            checkVal("out2", 32'(bus2.out), mOut2);
            checkVal("ovf2", 32'(bus2.overflow), 32'(mOvf2));
        end
    endtask

    // Drive one cycle of inputs, advance one edge, then check.
    task automatic applyStimulus(bit st, bit ld, bit sel, logic [N-1:0] par, bit d);
        bus4.start = st;  bus4.load_mode = ld;  bus4.count_sel = sel;
        bus4.par_in = par; bus4.D = d;
        bus2.start = st;  bus2.load_mode = ld;  bus2.count_sel = sel;
        bus2.par_in = par; bus2.D = d;
        @(posedge clock);
        if (reset) modelReset();
        else       modelEdge(st, ld, sel, par, d);
        #1;
        checkOutput();
    endtask

    // Full run: start edge plus N shift edges plus the DONE edge.
    task automatic runOnce(bit ld, bit sel, logic [N-1:0] par, bit d,
                           output int busyCycles, output int doneCycles);
        busyCycles = 0;
        doneCycles = 0;
        applyStimulus(1'b1, ld, sel, par, d);
        busyCycles += int'(bus4.busy);
        doneCycles += int'(bus4.done);
        repeat (N + 1) begin
            applyStimulus(1'b0, ld, sel, par, d);
            busyCycles += int'(bus4.busy);
            doneCycles += int'(bus4.done);
        end
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout reached");
        $fatal(1, "[TB] timeout");
    end

    // Directed plan steps followed by randomized runs.
    initial begin
        int bc, dc;
        logic [N-1:0] rp;
        bit rl, rs;

        bus4.start = 0; bus4.load_mode = 0; bus4.count_sel = 0; bus4.par_in = '0; bus4.D = 0;
        bus2.start = 0; bus2.load_mode = 0; bus2.count_sel = 0; bus2.par_in = '0; bus2.D = 0;
        modelReset();
        #12;
        checkVal("rst_busy", 32'(bus4.busy), 0);
        checkVal("rst_done", 32'(bus4.done), 0);
        checkVal("rst_out", 32'(bus4.out), 0);
        checkVal("rst_ovf", 32'(bus4.overflow), 0);
        reset = 1'b0;

        runOnce(1'b1, 1'b0, 8'b1011_0001, 1'b0, bc, dc);
        checkVal("ones_busy_cycles", bc, 9);
        checkVal("ones_done_pulses", dc, 1);
        checkVal("ones_out", 32'(bus4.out), 4);
        checkVal("ones_ovf", 32'(bus4.overflow), 0);
        checkVal("ones_out_h2", 32'(bus2.out), 3);
        checkVal("ones_ovf_h2", 32'(bus2.overflow), 1);

        runOnce(1'b1, 1'b1, 8'b1011_0001, 1'b0, bc, dc);
        checkVal("edges_out", 32'(bus4.out), 5);

        runOnce(1'b1, 1'b0, 8'hFF, 1'b0, bc, dc);
        checkVal("sat_out_h2", 32'(bus2.out), 3);
        checkVal("sat_ovf_h2", 32'(bus2.overflow), 1);
        checkVal("ff_out", 32'(bus4.out), 8);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkVal("ovf_clear_on_start", 32'(bus2.overflow), 0);
        repeat (N + 1) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        runOnce(1'b1, 1'b0, 8'h00, 1'b1, bc, dc);
        runOnce(1'b0, 1'b0, 8'h00, 1'b1, bc, dc);
        checkVal("serial_ones", 32'(bus4.out), 4);
        runOnce(1'b0, 1'b1, 8'h00, 1'b1, bc, dc);

        bc = 0; dc = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'b1011_0001, 1'b0);
        for (int i = 1; i <= N + 1; i++) begin
            applyStimulus(i == 3, 1'b1, 1'b1, 8'hFF, 1'b0);
            dc += int'(bus4.done);
        end
        checkVal("busy_start_out", 32'(bus4.out), 4);
        checkVal("busy_start_done", dc, 1);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("midrst_busy", 32'(bus4.busy), 0);
        checkVal("midrst_done", 32'(bus4.done), 0);
        checkVal("midrst_out", 32'(bus4.out), 0);
        checkVal("midrst_ovf_h2", 32'(bus2.overflow), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        runOnce(1'b1, 1'b1, 8'b1011_0001, 1'b0, bc, dc);
        checkVal("after_rst_out", 32'(bus4.out), 5);
        checkVal("after_rst_done", dc, 1);

        repeat (30) begin
            rp = N'($urandom);
            rl = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            applyStimulus(1'b1, rl, rs, rp, 1'($urandom_range(0, 1)));
            repeat (N + 1) begin
                applyStimulus($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 2)) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
